// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - shared state encodings and constants for the fetch sequencer
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2,
        FS_ERR   = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0 : presented to IF/ID whenever no valid instruction is held
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Sequential advance; the 32-bit add wraps 0xFFFF_FFFC back to 0
    function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] target);
        return |target[1:0];
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_pc_reg.sv
// rtl/pc_fetch_ctrl_pc_reg.sv - load-enable register with async active-low reset
module pc_fetch_ctrl_pc_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when enabled, otherwise hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - RV32I fetch-stage sequencer: PC, imem requests, redirects, flushes
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_i,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        misalign_err
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         kill_q, kill_d;
    logic         valid_q;
    logic         err_q;

    logic [31:0]  pc;
    logic [31:0]  pc_d;
    logic         pc_en;
    logic         if_load;
    logic         if_clr;
    logic         err_set;
    logic         flush;
    logic [31:0]  if_inst_q;

    // Architectural PC
    pc_fetch_ctrl_pc_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
        .clk  (clk),
        .rstn (rstn),
        .en   (pc_en),
        .d    (pc_d),
        .q    (pc)
    );

    // IF/ID payload: PC of the accepted fetch
    pc_fetch_ctrl_pc_reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_if_pc (
        .clk  (clk),
        .rstn (rstn),
        .en   (if_load),
        .d    (pc),
        .q    (if_pc)
    );

    // IF/ID payload: instruction word of the accepted fetch
    pc_fetch_ctrl_pc_reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_if_inst (
        .clk  (clk),
        .rstn (rstn),
        .en   (if_load),
        .d    (imem_rdata),
        .q    (if_inst_q)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FS_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Boot counter, kill flag, IF valid bit and sticky misalignment error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= 4'd0;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            kill_q <= kill_d;
            if (if_clr) begin
                valid_q <= 1'b0;
            end else if (if_load) begin
                valid_q <= 1'b1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next-state and control decode; redirect outranks stall and responses
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kill_d   = kill_q;
        pc_en    = 1'b0;
        pc_d     = pc;
        if_load  = 1'b0;
        if_clr   = 1'b0;
        err_set  = 1'b0;
        imem_req = 1'b0;
        flush    = 1'b0;
        case (state_q)
            FS_BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    state_d = FS_FETCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FS_FETCH: begin
                imem_req = 1'b1;
                if (redir_valid) begin
                    flush  = 1'b1;
                    if_clr = 1'b1;
                    if (is_misaligned(redir_target)) begin
                        err_set = 1'b1;
                        kill_d  = 1'b0;
                        state_d = FS_ERR;
                    end else begin
                        pc_en   = 1'b1;
                        pc_d    = redir_target;
                        // A response arriving this cycle is simply dropped;
                        // otherwise the one still in flight must be discarded later.
                        kill_d  = !imem_ready;
                        state_d = FS_FETCH;
                    end
                end else if (imem_ready) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                        if (!stall_i) begin
                            if_clr = 1'b1;
                        end
                    end else begin
                        if_load = 1'b1;
                        pc_en   = 1'b1;
                        pc_d    = pc_next_seq(pc);
                        if (stall_i) begin
                            state_d = FS_HOLD;
                        end
                    end
                end else if (!stall_i) begin
                    // Nothing returned and ID is free to advance: present a bubble
                    if_clr = 1'b1;
                end
            end
            FS_HOLD: begin
                if (redir_valid) begin
                    flush  = 1'b1;
                    if_clr = 1'b1;
                    kill_d = 1'b0;
                    if (is_misaligned(redir_target)) begin
                        err_set = 1'b1;
                        state_d = FS_ERR;
                    end else begin
                        pc_en   = 1'b1;
                        pc_d    = redir_target;
                        state_d = FS_FETCH;
                    end
                end else if (!stall_i) begin
                    state_d = FS_FETCH;
                end
            end
            FS_ERR: begin
                state_d = FS_ERR;
            end
            default: begin
                state_d = FS_ERR;
            end
        endcase
    end

    assign imem_addr    = pc;
    assign if_valid     = valid_q;
    assign if_inst      = valid_q ? if_inst_q : INST_NOP;
    assign flush_ifid   = flush;
    assign flush_idex   = flush;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - vector/scoreboard bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall_i = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misalign_err;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .BOOT_CYCLES(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .stall_i      (stall_i),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        stall;
        logic        rv;
        logic [31:0] rt;
        logic        rdy;
        logic [31:0] raddr;
        logic        req;
        logic [31:0] addr;
        logic        ca;
        logic        ifv;
        logic [31:0] ifpc;
        logic        flush;
        logic        err;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[16];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0003;
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [31:0] rt,
                                input logic rdy, input logic [31:0] raddr,
                                input logic req, input logic [31:0] addr, input logic ca,
                                input logic ifv, input logic [31:0] ifpc,
                                input logic fl, input logic err);
        vec_t v;
        v.rstn = r; v.stall = s; v.rv = rv; v.rt = rt; v.rdy = rdy; v.raddr = raddr;
        v.req = req; v.addr = addr; v.ca = ca; v.ifv = ifv; v.ifpc = ifpc;
        v.flush = fl; v.err = err;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rstn         = v.rstn;
        stall_i      = v.stall;
        redir_valid  = v.rv;
        redir_target = v.rt;
        imem_ready   = v.rdy;
        imem_rdata   = inst_of(v.raddr);
        sb.push_back(v);
    endtask

    // Compare each cycle's outputs half a period after the inputs settle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t  e;
            logic [31:0] e_inst;
            logic  bad;
            e = sb.pop_front();
            e_inst = e.ifv ? inst_of(e.ifpc) : NOP;
            bad = (imem_req !== e.req) || (if_valid !== e.ifv) || (if_inst !== e_inst) ||
                  (flush_ifid !== e.flush) || (flush_idex !== e.flush) ||
                  (misalign_err !== e.err) ||
                  (e.ca && (imem_addr !== e.addr)) ||
                  (e.ifv && (if_pc !== e.ifpc));
            n_vec++;
            if (bad) begin
                n_bad++;
                $display("FAIL vec%0d got req=%b addr=%h ifv=%b ifpc=%h inst=%h fl=%b/%b err=%b want req=%b addr=%h ifv=%b ifpc=%h inst=%h fl=%b err=%b",
                         n_vec - 1, imem_req, imem_addr, if_valid, if_pc, if_inst, flush_ifid,
                         flush_idex, misalign_err, e.req, e.addr, e.ifv, e.ifpc, e_inst,
                         e.flush, e.err);
            end
        end
    end

    initial begin
        // Reset, boot, sequential fetch, stall/hold, redirect over stall, bubble
        tbl[0]  = mk(0, 0, 1, 32'h300, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 0);
        tbl[1]  = mk(1, 0, 1, 32'h300, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 0);
        tbl[2]  = mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 0);
        tbl[3]  = mk(1, 0, 0, 32'h0,   1, 32'h0,   1, 32'h0,   1, 0, 32'h0,   0, 0);
        tbl[4]  = mk(1, 0, 0, 32'h0,   1, 32'h4,   1, 32'h4,   1, 1, 32'h0,   0, 0);
        tbl[5]  = mk(1, 1, 0, 32'h0,   1, 32'h8,   1, 32'h8,   1, 1, 32'h4,   0, 0);
        tbl[6]  = mk(1, 1, 0, 32'h0,   1, 32'hC,   0, 32'hC,   1, 1, 32'h8,   0, 0);
        tbl[7]  = mk(1, 1, 0, 32'h0,   1, 32'hC,   0, 32'hC,   1, 1, 32'h8,   0, 0);
        tbl[8]  = mk(1, 0, 0, 32'h0,   1, 32'hC,   0, 32'hC,   1, 1, 32'h8,   0, 0);
        tbl[9]  = mk(1, 0, 0, 32'h0,   1, 32'hC,   1, 32'hC,   1, 1, 32'h8,   0, 0);
        tbl[10] = mk(1, 1, 0, 32'h0,   1, 32'h10,  1, 32'h10,  1, 1, 32'hC,   0, 0);
        tbl[11] = mk(1, 1, 1, 32'h100, 1, 32'h14,  0, 32'h14,  1, 1, 32'h10,  1, 0);
        tbl[12] = mk(1, 0, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 0, 32'h0,   0, 0);
        tbl[13] = mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h104, 1, 1, 32'h100, 0, 0);
        tbl[14] = mk(1, 0, 0, 32'h0,   1, 32'h104, 1, 32'h104, 1, 0, 32'h0,   0, 0);
        tbl[15] = mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h108, 1, 1, 32'h104, 0, 0);
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i]);
        end

        // Redirect coinciding with a response, then redirect over a pending fetch
        apply(mk(1, 0, 1, 32'h40,  1, 32'h108, 1, 32'h108, 1, 0, 32'h0,   1, 0));
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h40,  1, 0, 32'h0,   0, 0));
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h40,  1, 0, 32'h0,   0, 0));
        apply(mk(1, 0, 1, 32'h200, 0, 32'h0,   1, 32'h40,  1, 0, 32'h0,   1, 0));
        apply(mk(1, 0, 0, 32'h0,   1, 32'h40,  1, 32'h200, 1, 0, 32'h0,   0, 0));
        apply(mk(1, 0, 0, 32'h0,   1, 32'h200, 1, 32'h200, 1, 0, 32'h0,   0, 0));
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h204, 1, 1, 32'h200, 0, 0));

        // Misaligned redirect: terminal error state
        apply(mk(1, 0, 1, 32'h202, 0, 32'h0,   1, 32'h204, 1, 0, 32'h0,   1, 0));
        apply(mk(1, 0, 1, 32'h300, 1, 32'h204, 0, 32'h0,   0, 0, 32'h0,   0, 1));
        apply(mk(1, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0,   0, 0, 32'h0,   0, 1));

        // Reset clears the error, then async reset during a pending fetch at 0x80
        apply(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 0));
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 0));
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 0));
        apply(mk(1, 0, 1, 32'h80,  0, 32'h0,   1, 32'h0,   1, 0, 32'h0,   1, 0));
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  1, 0, 32'h0,   0, 0));
        apply(mk(0, 0, 1, 32'h300, 1, 32'h80,  0, 32'h0,   1, 0, 32'h0,   0, 0));
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 0));
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 0));
        apply(mk(1, 0, 0, 32'h0,   1, 32'h0,   1, 32'h0,   1, 0, 32'h0,   0, 0));
        apply(mk(1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h4,   1, 1, 32'h0,   0, 0));

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
